// File: rtl/sdram_arb.sv
// Two-port (CPU read/write, video read-only) arbiter in front of an SDRAM controller.
// One transaction in flight; every issue is followed by a guard wait, a completion and a one-cycle gap.
module sdram_arb #(
  parameter int unsigned GUARD        = 2,
  parameter int unsigned VID_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [24:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic [1:0]  cpu_wtbt,
  input  logic        cpu_we,
  input  logic        cpu_rd,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,
  input  logic [24:0] vid_addr,
  input  logic        vid_req,
  output logic [15:0] vid_dout,
  output logic        vid_ack,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_wtbt,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [15:0] mem_dout,
  input  logic        mem_ready
);

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t        state;
  logic [CW-1:0] guard_cnt;
  logic          grant_vid;
  logic          last_vid;
  logic          cpu_req_c;
  logic          grant_vid_c;

  // Arbitration: fixed video priority, or on a tie the port not served last
  always_comb begin
    cpu_req_c   = cpu_we | cpu_rd;
    grant_vid_c = 1'b0;
    if (VID_PRIORITY != 0) grant_vid_c = vid_req;
    else                   grant_vid_c = vid_req & (~cpu_req_c | ~last_vid);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      guard_cnt <= '0;
      grant_vid <= 1'b0;
      last_vid  <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_wtbt  <= '0;
      mem_we    <= 1'b0;
      mem_rd    <= 1'b0;
      cpu_dout  <= '0;
      vid_dout  <= '0;
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_ready && (vid_req || cpu_req_c)) begin
            grant_vid <= grant_vid_c;
            last_vid  <= grant_vid_c;
            guard_cnt <= CW'(GUARD);
            state     <= ISSUE;
            if (grant_vid_c) begin
              mem_addr <= vid_addr;
              mem_din  <= DW'(0);
              mem_wtbt <= 2'b00;
              mem_rd   <= 1'b1;
              mem_we   <= 1'b0;
            end else begin
              // A simultaneous write request overrides the read
              mem_addr <= AW'(cpu_addr);
              mem_din  <= cpu_din;
              mem_wtbt <= cpu_wtbt;
              mem_we   <= cpu_we;
              mem_rd   <= ~cpu_we;
            end
          end
        end
        ISSUE: begin
          guard_cnt <= guard_cnt - CW'(1);
          if (guard_cnt == CW'(1)) state <= WAIT;
        end
        WAIT: begin
          if (mem_ready) begin
            mem_rd <= 1'b0;
            mem_we <= 1'b0;
            state  <= GAP;
            if (grant_vid) begin
              vid_ack <= 1'b1;
              if (mem_rd) vid_dout <= mem_dout;
            end else begin
              cpu_ack <= 1'b1;
              if (mem_rd) cpu_dout <= mem_dout;
            end
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Scoreboard bench for sdram_arb: one fixed-priority and one round-robin instance share
// the stimulus; a controller model and monitor check the instance selected by sel.
module tb_sdram_arb;

  localparam int unsigned GUARD = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [24:0] cpu_addr = '0;
  logic [15:0] cpu_din = '0;
  logic [1:0]  cpu_wtbt = 2'b11;
  logic        cpu_we_lvl = 1'b0, cpu_rd_lvl = 1'b0;
  logic [24:0] vid_addr = '0;
  int unsigned cpu_done = 0, cpu_target = 0, vid_done = 0, vid_target = 0;
  logic        cpu_we, cpu_rd, vid_req;
  logic        model_ready = 1'b1, force_low = 1'b0;
  logic        mem_ready;
  logic        ovr_en = 1'b0;
  logic [15:0] ovr_data = '0;
  logic [15:0] mem_dout;
  logic        sel = 1'b1;

  logic [15:0] p1_cpu_dout, p0_cpu_dout, p1_vid_dout, p0_vid_dout, p1_mem_din, p0_mem_din;
  logic        p1_cpu_ack, p0_cpu_ack, p1_vid_ack, p0_vid_ack;
  logic [24:0] p1_mem_addr, p0_mem_addr;
  logic [1:0]  p1_mem_wtbt, p0_mem_wtbt;
  logic        p1_mem_we, p0_mem_we, p1_mem_rd, p0_mem_rd;

  logic [15:0] m_cpu_dout, m_vid_dout, m_din;
  logic        m_cpu_ack, m_vid_ack, m_we, m_rd;
  logic [24:0] m_addr;
  logic [1:0]  m_wtbt;

  always #5 clk = ~clk;

  // Requests stay high until the wanted number of acks has been seen
  assign cpu_we    = cpu_we_lvl && (cpu_done != cpu_target);
  assign cpu_rd    = cpu_rd_lvl && (cpu_done != cpu_target);
  assign vid_req   = (vid_done != vid_target);
  assign mem_ready = model_ready & ~force_low;
  assign mem_dout  = ovr_en ? ovr_data : (16'(m_addr) ^ 16'h5A5A);

  sdram_arb #(.GUARD(GUARD), .VID_PRIORITY(1)) u_prio (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wtbt(cpu_wtbt), .cpu_we(cpu_we), .cpu_rd(cpu_rd),
    .cpu_dout(p1_cpu_dout), .cpu_ack(p1_cpu_ack),
    .vid_addr(vid_addr), .vid_req(vid_req), .vid_dout(p1_vid_dout), .vid_ack(p1_vid_ack),
    .mem_addr(p1_mem_addr), .mem_din(p1_mem_din), .mem_wtbt(p1_mem_wtbt), .mem_we(p1_mem_we),
    .mem_rd(p1_mem_rd), .mem_dout(mem_dout), .mem_ready(mem_ready));

  sdram_arb #(.GUARD(GUARD), .VID_PRIORITY(0)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wtbt(cpu_wtbt), .cpu_we(cpu_we), .cpu_rd(cpu_rd),
    .cpu_dout(p0_cpu_dout), .cpu_ack(p0_cpu_ack),
    .vid_addr(vid_addr), .vid_req(vid_req), .vid_dout(p0_vid_dout), .vid_ack(p0_vid_ack),
    .mem_addr(p0_mem_addr), .mem_din(p0_mem_din), .mem_wtbt(p0_mem_wtbt), .mem_we(p0_mem_we),
    .mem_rd(p0_mem_rd), .mem_dout(mem_dout), .mem_ready(mem_ready));

  always_comb begin
    m_cpu_dout = sel ? p1_cpu_dout : p0_cpu_dout;
    m_vid_dout = sel ? p1_vid_dout : p0_vid_dout;
    m_cpu_ack  = sel ? p1_cpu_ack  : p0_cpu_ack;
    m_vid_ack  = sel ? p1_vid_ack  : p0_vid_ack;
    m_addr     = sel ? p1_mem_addr : p0_mem_addr;
    m_din      = sel ? p1_mem_din  : p0_mem_din;
    m_wtbt     = sel ? p1_mem_wtbt : p0_mem_wtbt;
    m_we       = sel ? p1_mem_we   : p0_mem_we;
    m_rd       = sel ? p1_mem_rd   : p0_mem_rd;
  end

  typedef struct {
    logic        vid;
    logic        wr;
    logic [24:0] addr;
    logic [15:0] din;
    logic [1:0]  wtbt;
  } exp_t;

  typedef struct {
    logic        vid;
    logic        wr;
    logic [24:0] addr;
    logic [15:0] data;
    int unsigned issue_cyc;
    int unsigned lat;
  } pend_t;

  exp_t  exp_q[$];
  pend_t ack_q[$];

  int unsigned n_checks = 0, n_pass = 0, n_acks = 0;
  int unsigned cyc = 0;
  int unsigned stall_len = 0;
  logic        rr_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model and monitor
  int unsigned stall_cnt = 0, last_issue = 0;
  logic        prev_act = 1'b0, in_gap = 1'b0, have_prev = 1'b0;
  logic [15:0] last_cpu = '0, last_vid = '0;
  exp_t        e;
  pend_t       p;

  always @(negedge clk) begin
    if (!reset_n) begin
      model_ready = 1'b1;
      stall_cnt   = 0;
      prev_act    = 1'b0;
      in_gap      = 1'b0;
      have_prev   = 1'b0;
      last_cpu    = '0;
      last_vid    = '0;
    end else begin
      if (in_gap) begin
        chk("gap_low", 32'({m_rd, m_we}), 32'd0);
        in_gap = 1'b0;
      end
      if (stall_cnt > 0) begin
        stall_cnt--;
        if (stall_cnt == 0) model_ready = 1'b1;
      end
      if ((m_rd || m_we) && !prev_act) begin
        if (exp_q.size() == 0) chk("spurious_issue", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("issue_addr", 32'(m_addr), 32'(e.addr));
          chk("issue_din",  32'(m_din),  32'(e.din));
          chk("issue_wtbt", 32'(m_wtbt), 32'(e.wtbt));
          chk("issue_we",   32'(m_we),   32'(e.wr));
          chk("issue_rd",   32'(m_rd),   32'(!e.wr));
          if (rr_mode && have_prev) chk("issue_spacing", cyc - last_issue, GUARD + 3);
          p.vid = e.vid; p.wr = e.wr; p.addr = e.addr; p.issue_cyc = cyc;
          p.data = ovr_en ? ovr_data : (16'(e.addr) ^ 16'h5A5A);
          p.lat  = (stall_len > GUARD) ? stall_len + 1 : GUARD + 1;
          ack_q.push_back(p);
          if (stall_len > 0) begin
            model_ready = 1'b0;
            stall_cnt   = stall_len;
          end
        end
        last_issue = cyc;
        have_prev  = 1'b1;
      end
      prev_act = m_rd || m_we;
      if (m_cpu_ack || m_vid_ack) begin
        chk("one_ack", 32'(m_cpu_ack & m_vid_ack), 32'd0);
        chk("ack_rdwe_low", 32'({m_rd, m_we}), 32'd0);
        in_gap = 1'b1;
        if (ack_q.size() == 0) chk("spurious_ack", 32'd1, 32'd0);
        else begin
          p = ack_q.pop_front();
          chk("ack_port", 32'(m_vid_ack), 32'(p.vid));
          chk("ack_latency", cyc - p.issue_cyc, p.lat);
          chk("addr_held", 32'(m_addr), 32'(p.addr));
          if (p.vid) begin
            if (!p.wr) last_vid = p.data;
            chk("vid_dout", 32'(m_vid_dout), 32'(last_vid));
          end else begin
            if (!p.wr) last_cpu = p.data;
            chk("cpu_dout", 32'(m_cpu_dout), 32'(last_cpu));
          end
        end
        n_acks++;
        if (m_vid_ack) vid_done++;
        else           cpu_done++;
      end
    end
  end

  task automatic wait_acks(input int unsigned target, input int unsigned budget);
    int unsigned k = 0;
    while (n_acks < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (n_acks < target) chk("ack_timeout", n_acks, target);
    repeat (3) @(negedge clk);
  endtask

  task automatic push_exp(input logic vid, input logic wr, input logic [24:0] addr,
                          input logic [15:0] din, input logic [1:0] wtbt);
    exp_t x;
    x.vid = vid; x.wr = wr; x.addr = addr; x.din = din; x.wtbt = wtbt;
    exp_q.push_back(x);
  endtask

  task automatic cpu_req(input logic we, input logic rd, input logic [24:0] addr,
                         input logic [15:0] din, input logic [1:0] wtbt, input int unsigned n);
    cpu_we_lvl = we; cpu_rd_lvl = rd; cpu_addr = addr; cpu_din = din; cpu_wtbt = wtbt;
    cpu_target = cpu_done + n;
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_rd",   32'(m_rd),       32'd0);
    chk("rst_mem_we",   32'(m_we),       32'd0);
    chk("rst_acks",     32'({m_cpu_ack, m_vid_ack}), 32'd0);
    chk("rst_mem_addr", 32'(m_addr),     32'd0);
    chk("rst_mem_din",  32'(m_din),      32'd0);
    chk("rst_mem_wtbt", 32'(m_wtbt),     32'd0);
    chk("rst_cpu_dout", 32'(m_cpu_dout), 32'd0);
    chk("rst_vid_dout", 32'(m_vid_dout), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read with controller stall: data 0x1234 arrives after 4 not-ready cycles
    stall_len = 4; ovr_en = 1'b1; ovr_data = 16'h1234;
    push_exp(1'b0, 1'b0, 25'h0000100, 16'h0000, 2'b11);
    cpu_req(1'b0, 1'b1, 25'h0000100, 16'h0000, 2'b11, 1);
    @(posedge clk); #1;
    chk("rd_one_cycle", 32'(m_rd), 32'd1);
    wait_acks(1, 40);
    ovr_en = 1'b0; stall_len = 0;

    // Simultaneous CPU write and video read: video first
    push_exp(1'b1, 1'b0, 25'h1000040, 16'h0000, 2'b00);
    push_exp(1'b0, 1'b1, 25'h00ABCDE, 16'hBEEF, 2'b01);
    vid_addr = 25'h1000040; vid_target = vid_done + 1;
    cpu_req(1'b1, 1'b0, 25'h00ABCDE, 16'hBEEF, 2'b01, 1);
    wait_acks(3, 40);

    // Read hit; address changes after grant must not disturb the transaction
    push_exp(1'b0, 1'b0, 25'h0000200, 16'h0000, 2'b11);
    cpu_req(1'b0, 1'b1, 25'h0000200, 16'h0000, 2'b11, 1);
    @(negedge clk);
    cpu_addr = 25'h1555555;
    wait_acks(4, 40);

    // Write and read together at the top address: write only, cpu_dout kept
    push_exp(1'b0, 1'b1, 25'h1FFFFFE, 16'h55AA, 2'b11);
    cpu_req(1'b1, 1'b1, 25'h1FFFFFE, 16'h55AA, 2'b11, 1);
    wait_acks(5, 40);

    // Reset during WAIT aborts; no issue while mem_ready is low afterwards
    stall_len = 20;
    push_exp(1'b0, 1'b0, 25'h0000300, 16'h0000, 2'b11);
    cpu_req(1'b0, 1'b1, 25'h0000300, 16'h0000, 2'b11, 1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0; force_low = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete(); ack_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stall_len = 0;
    repeat (6) begin
      @(negedge clk);
      chk("no_issue_not_ready", 32'({m_rd, m_we}), 32'd0);
    end
    chk("no_ack_after_abort", n_acks, 32'd5);
    push_exp(1'b0, 1'b0, 25'h0000300, 16'h0000, 2'b11);
    force_low = 1'b0;
    wait_acks(6, 40);

    // Round-robin instance: continuous requests alternate V,C,V,C,V,C
    reset_n = 1'b0;
    #1;
    sel = 1'b0;
    exp_q.delete(); ack_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rr_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b1, 1'b0, 25'h0000800, 16'h0000, 2'b00);
      push_exp(1'b0, 1'b0, 25'h0000400, 16'h0000, 2'b11);
    end
    vid_addr = 25'h0000800; vid_target = vid_done + 3;
    cpu_req(1'b0, 1'b1, 25'h0000400, 16'h0000, 2'b11, 3);
    wait_acks(12, 100);
    chk("rr_queue_empty", 32'(exp_q.size() + ack_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
